// File: rtl/lsu_store_rv32.sv
// RV32 store unit: aligns store data, builds byte strobes and runs one
// write transaction over AW/W/B, reporting done/err/misalign.
module lsu_store_rv32 #(
    parameter int DATA_LEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_LEN-1:0]   req_addr,
    input  logic [DATA_LEN-1:0]   req_data,
    input  logic                  req_byte,
    input  logic                  req_half,
    input  logic                  req_word,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_LEN-1:0]   awaddr,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [DATA_LEN-1:0]   wdata,
    output logic [DATA_LEN/8-1:0] wstrb,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,
    output logic                  done,
    output logic                  err,
    output logic                  misalign
);

    localparam int SW = DATA_LEN / 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_B,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  misalign_q, misalign_d;
    logic [DATA_LEN-1:0]   awaddr_q, awaddr_d;
    logic [DATA_LEN-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]         wstrb_q, wstrb_d;

    logic                  size_ok;
    logic                  align_ok;
    logic [DATA_LEN-1:0]   lane_data;
    logic [SW-1:0]         lane_strb;

    // Request legality and lane replication, computed from the live request
    always_comb begin
        size_ok   = 1'b0;
        lane_data = req_data;
        lane_strb = {SW{1'b1}};
        case ({req_word, req_half, req_byte})
            3'b001: begin
                size_ok   = 1'b1;
                lane_data = {SW{req_data[7:0]}};
                lane_strb = SW'(1) << req_addr[1:0];
            end
            3'b010: begin
                size_ok   = 1'b1;
                lane_data = {(SW/2){req_data[15:0]}};
                lane_strb = SW'(3) << req_addr[1:0];
            end
            3'b100: begin
                size_ok   = 1'b1;
                lane_data = req_data;
                lane_strb = {SW{1'b1}};
            end
            default: begin
                size_ok   = 1'b0;
            end
        endcase
        align_ok = !(req_half && req_addr[0])
                && !(req_word && (req_addr[1:0] != 2'b00));
    end

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        done_d      = done_q;
        err_d       = err_q;
        misalign_d  = misalign_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    if (!(size_ok && align_ok)) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                        err_d      = 1'b0;
                    end else begin
                        state_d   = SEND;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = {req_addr[DATA_LEN-1:2], 2'b00};
                        wdata_d   = lane_data;
                        wstrb_d   = lane_strb;
                    end
                end
            end
            SEND: begin
                // A low valid here means that channel already handshook
                if (awvalid_q && awready) awvalid_d = 1'b0;
                if (wvalid_q && wready)   wvalid_d  = 1'b0;
                if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
                    state_d  = WAIT_B;
                    bready_d = 1'b1;
                end
            end
            WAIT_B: begin
                if (bvalid) begin
                    state_d  = DONE;
                    bready_d = 1'b0;
                    done_d   = 1'b1;
                    err_d    = (bresp != 2'b00);
                end
            end
            DONE: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                done_d      = 1'b0;
                err_d       = 1'b0;
                misalign_d  = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            misalign_q  <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            misalign_q  <= misalign_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
        end
    end

    assign req_ready = req_ready_q;
    assign awvalid   = awvalid_q;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;
    assign done      = done_q;
    assign err       = err_q;
    assign misalign  = misalign_q;
    assign awaddr    = awaddr_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;

endmodule

// File: tb/tb_lsu_store_rv32.sv
// Directed bench for lsu_store_rv32: vector table of stores with bus
// delays plus hand sequences for reset and recovery.
module tb_lsu_store_rv32;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_byte;
    logic        req_half;
    logic        req_word;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        done;
    logic        err;
    logic        misalign;

    int n_vec  = 0;
    int n_fail = 0;

    lsu_store_rv32 #(.DATA_LEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .req_byte(req_byte), .req_half(req_half), .req_word(req_word),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .done(done), .err(err), .misalign(misalign)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] SB = 3'b001;
    localparam logic [2:0] SH = 3'b010;
    localparam logic [2:0] SWD = 3'b100;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  sz;
        int          aw_d;
        int          w_d;
        int          b_d;
        logic [1:0]  resp;
        logic [31:0] ex_awaddr;
        logic [31:0] ex_wdata;
        logic [3:0]  ex_wstrb;
        logic        ex_err;
        logic        ex_mis;
        int          ex_lat;
    } vec_t;

    vec_t vt[14];

    function automatic vec_t mk(
        input logic [31:0] a, input logic [31:0] d, input logic [2:0] s,
        input int awd, input int wd, input int bd, input logic [1:0] r,
        input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] es,
        input logic ee, input logic em, input int el);
        vec_t v;
        v.addr = a; v.data = d; v.sz = s;
        v.aw_d = awd; v.w_d = wd; v.b_d = bd; v.resp = r;
        v.ex_awaddr = ea; v.ex_wdata = ed; v.ex_wstrb = es;
        v.ex_err = ee; v.ex_mis = em; v.ex_lat = el;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int awc = 0, wc = 0, bcnt = 0, stab = 0, rrerr = 0, lat = 0;
        logic [31:0] a0 = '0, d0 = '0;
        logic [3:0]  s0 = '0;
        logic e = 1'b0, m = 1'b0;
        bit seen = 0;
        chk({nm, ".req_ready_idle"}, 32'(req_ready), 32'd1);
        req_addr = v.addr;
        req_data = v.data;
        {req_word, req_half, req_byte} = v.sz;
        req_valid = 1'b1;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = v.resp;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr = 32'hFFFF_FFFF;
        req_data = 32'h0;
        {req_word, req_half, req_byte} = 3'b000;
        for (int k = 1; k <= 40 && !seen; k++) begin
            if (awvalid) begin
                if (awc == 0) a0 = awaddr;
                else if (awaddr !== a0) stab++;
                awc++;
            end
            if (wvalid) begin
                if (wc == 0) begin d0 = wdata; s0 = wstrb; end
                else if ({wdata, wstrb} !== {d0, s0}) stab++;
                wc++;
            end
            if (bready) bcnt++;
            if (req_ready) rrerr++;
            if (done) begin
                seen = 1; lat = k; e = err; m = misalign;
            end else begin
                awready = (k > v.aw_d);
                wready  = (k > v.w_d);
                bvalid  = bready && (bcnt > v.b_d);
                @(posedge clk); #1;
            end
        end
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        chk({nm, ".done_cycle"}, 32'(lat), 32'(v.ex_lat));
        chk({nm, ".err"}, 32'(e), 32'(v.ex_err));
        chk({nm, ".misalign"}, 32'(m), 32'(v.ex_mis));
        chk({nm, ".awvalid_cycles"}, 32'(awc),
            v.ex_mis ? 32'd0 : 32'(v.aw_d + 1));
        chk({nm, ".wvalid_cycles"}, 32'(wc),
            v.ex_mis ? 32'd0 : 32'(v.w_d + 1));
        chk({nm, ".bready_cycles"}, 32'(bcnt),
            v.ex_mis ? 32'd0 : 32'(v.b_d + 1));
        chk({nm, ".stable"}, 32'(stab), 32'd0);
        chk({nm, ".busy_ready"}, 32'(rrerr), 32'd0);
        if (!v.ex_mis) begin
            chk({nm, ".awaddr"}, a0, v.ex_awaddr);
            chk({nm, ".wdata"}, d0, v.ex_wdata);
            chk({nm, ".wstrb"}, 32'(s0), 32'(v.ex_wstrb));
        end
        @(posedge clk); #1;
        chk({nm, ".after_done"}, 32'({done, err, misalign, req_ready}),
            32'b0001);
    endtask

    initial begin
        int dcnt;
        int bwait;
        vt[0]  = mk(32'h8000_0003, 32'h1234_56AB, SB, 0, 0, 0, 2'b00,
                    32'h8000_0000, 32'hABAB_ABAB, 4'b1000, 0, 0, 3);
        vt[1]  = mk(32'h8000_0002, 32'hDEAD_BEEF, SH, 0, 0, 0, 2'b00,
                    32'h8000_0000, 32'hBEEF_BEEF, 4'b1100, 0, 0, 3);
        vt[2]  = mk(32'h8000_0004, 32'hCAFE_F00D, SWD, 0, 0, 0, 2'b00,
                    32'h8000_0004, 32'hCAFE_F00D, 4'b1111, 0, 0, 3);
        vt[3]  = mk(32'h8000_0001, 32'h1111_2222, SWD, 0, 0, 0, 2'b00,
                    32'h0, 32'h0, 4'b0000, 0, 1, 1);
        vt[4]  = mk(32'h8000_0000, 32'h3333_4444, 3'b011, 0, 0, 0, 2'b00,
                    32'h0, 32'h0, 4'b0000, 0, 1, 1);
        vt[5]  = mk(32'h0000_0011, 32'h0000_0000, SH, 0, 0, 0, 2'b00,
                    32'h0, 32'h0, 4'b0000, 0, 1, 1);
        vt[6]  = mk(32'h1000_0001, 32'h0000_00C3, SB, 0, 0, 0, 2'b00,
                    32'h1000_0000, 32'hC3C3_C3C3, 4'b0010, 0, 0, 3);
        vt[7]  = mk(32'h2000_0000, 32'hFFFF_1234, SH, 0, 0, 0, 2'b00,
                    32'h2000_0000, 32'h1234_1234, 4'b0011, 0, 0, 3);
        vt[8]  = mk(32'h4000_0006, 32'h0000_005A, SB, 3, 0, 2, 2'b00,
                    32'h4000_0004, 32'h5A5A_5A5A, 4'b0100, 0, 0, 8);
        vt[9]  = mk(32'h0000_0100, 32'h1122_3344, SWD, 0, 0, 0, 2'b10,
                    32'h0000_0100, 32'h1122_3344, 4'b1111, 1, 0, 3);
        vt[10] = mk(32'h0000_0104, 32'h5566_7788, SWD, 0, 0, 0, 2'b00,
                    32'h0000_0104, 32'h5566_7788, 4'b1111, 0, 0, 3);
        vt[11] = mk(32'h3000_000A, 32'hAAAA_5555, SH, 0, 2, 1, 2'b11,
                    32'h3000_0008, 32'h5555_5555, 4'b1100, 1, 0, 6);
        vt[12] = mk(32'h0000_0200, 32'h9999_9999, 3'b000, 0, 0, 0, 2'b00,
                    32'h0, 32'h0, 4'b0000, 0, 1, 1);
        vt[13] = mk(32'h0000_0202, 32'h7777_7777, SWD, 0, 0, 0, 2'b00,
                    32'h0, 32'h0, 4'b0000, 0, 1, 1);

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0;
        req_byte = 1'b0; req_half = 1'b0; req_word = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ctrl", 32'({awvalid, wvalid, bready, done, err,
                               misalign, req_ready}), 32'b0000001);
        chk("reset.awaddr", awaddr, 32'h0);
        chk("reset.wdata", wdata, 32'h0);
        chk("reset.wstrb", 32'(wstrb), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++)
            run_vec(vt[i], $sformatf("vec%0d", i));

        // Reset while waiting for the write response
        req_addr = 32'h0000_0050; req_data = 32'h0BAD_F00D;
        {req_word, req_half, req_byte} = SWD;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        awready = 1'b1; wready = 1'b1;
        bwait = 0;
        while (!bready && bwait < 10) begin
            @(posedge clk); #1;
            bwait++;
        end
        awready = 1'b0; wready = 1'b0;
        chk("rstmid.reached_wait_b", 32'(bready), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid.ctrl", 32'({awvalid, wvalid, bready, done,
                                req_ready}), 32'b00001);
        chk("rstmid.wstrb", 32'(wstrb), 32'h0);
        bvalid = 1'b1; bresp = 2'b00;
        dcnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        bvalid = 1'b0;
        chk("rstmid.no_done", 32'(dcnt), 32'd0);
        chk("rstmid.ready", 32'(req_ready), 32'd1);

        run_vec(vt[0], "recover");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
